// File: rtl/seg_display_arbiter.sv
// Two-client arbiter for an 8-digit seven-segment scan driver: generates the
// digit strobe, hands the display to one client at a time and blanks on switches.
module seg_display_arbiter #(
  parameter int unsigned CE_DIV      = 100000,
  parameter int unsigned HOLD_FRAMES = 64,
  parameter int unsigned GAP_FRAMES  = 2
) (
  input  logic        CLK_100,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        REQ_A,
  input  logic        REQ_B,
  input  logic [31:0] HEX_A,
  input  logic [31:0] HEX_B,
  input  logic [7:0]  BLANK_A,
  input  logic [7:0]  BLANK_B,
  input  logic [7:0]  DP_A,
  input  logic [7:0]  DP_B,
  output logic        GNT_A,
  output logic        GNT_B,
  output logic        CE_OUT,
  output logic        FRAME_END,
  output logic [31:0] HEX_OUT,
  output logic [7:0]  BLANK_OUT,
  output logic [7:0]  DP_OUT
);

  localparam int unsigned PW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int unsigned FW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam int unsigned GW = (GAP_FRAMES > 0) ? $clog2(GAP_FRAMES + 1) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CE_DIV - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP} state_t;

  state_t        state, state_nx;
  logic          last_b, last_b_nx;
  logic [PW-1:0] pre_cnt;
  logic [2:0]    digit;
  logic [FW-1:0] frames, frames_nx, frames_inc;
  logic [GW-1:0] gaps, gaps_nx;
  logic          tick_c, frame_c, hold_met_c, gap_done_c;

  assign tick_c  = EN && (pre_cnt == PRE_MAX);
  assign frame_c = tick_c && (digit == 3'd7);

  // Grant the sole requester; on a tie, the client that did not own last.
  function automatic state_t arbitrate(input logic ra, input logic rb, input logic lb);
    if (ra && rb) return lb ? OWN_A : OWN_B;
    if (ra)       return OWN_A;
    if (rb)       return OWN_B;
    return IDLE;
  endfunction

  // Prescaler, digit counter and the two strobes
  always_ff @(posedge CLK_100 or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt   <= '0;
      digit     <= '0;
      CE_OUT    <= 1'b0;
      FRAME_END <= 1'b0;
    end else begin
      if (EN) pre_cnt <= tick_c ? '0 : pre_cnt + PW'(1);
      if (tick_c) digit <= digit + 3'd1;
      CE_OUT    <= tick_c;
      FRAME_END <= frame_c;
    end
  end

  always_ff @(posedge CLK_100 or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      last_b <= 1'b1;
      frames <= '0;
      gaps   <= '0;
      GNT_A  <= 1'b0;
      GNT_B  <= 1'b0;
    end else begin
      state  <= state_nx;
      last_b <= last_b_nx;
      frames <= frames_nx;
      gaps   <= gaps_nx;
      GNT_A  <= (state_nx == OWN_A);
      GNT_B  <= (state_nx == OWN_B);
    end
  end

  // Ownership decisions happen only at frame boundaries
  always_comb begin
    state_nx   = state;
    last_b_nx  = last_b;
    frames_nx  = frames;
    gaps_nx    = gaps;
    frames_inc = (32'(frames) >= HOLD_FRAMES) ? frames : frames + FW'(1);
    hold_met_c = (32'(frames_inc) >= HOLD_FRAMES);
    gap_done_c = ((32'(gaps) + 32'd1) >= GAP_FRAMES);

    if (frame_c) begin
      case (state)
        IDLE: state_nx = arbitrate(REQ_A, REQ_B, last_b);
        OWN_A: begin
          frames_nx = frames_inc;
          if (!REQ_A || (REQ_B && hold_met_c)) begin
            last_b_nx = 1'b0;
            gaps_nx   = '0;
            if (GAP_FRAMES == 0) state_nx = arbitrate(REQ_A, REQ_B, 1'b0);
            else                 state_nx = REQ_B ? GAP : IDLE;
          end
        end
        OWN_B: begin
          frames_nx = frames_inc;
          if (!REQ_B || (REQ_A && hold_met_c)) begin
            last_b_nx = 1'b1;
            gaps_nx   = '0;
            if (GAP_FRAMES == 0) state_nx = arbitrate(REQ_A, REQ_B, 1'b1);
            else                 state_nx = REQ_A ? GAP : IDLE;
          end
        end
        GAP: begin
          if (gap_done_c) state_nx = arbitrate(REQ_A, REQ_B, last_b);
          else            gaps_nx  = gaps + GW'(1);
        end
        default: state_nx = IDLE;
      endcase
      if ((state_nx == OWN_A || state_nx == OWN_B) && state_nx != state) frames_nx = '0;
    end
  end

  // Display data follows the current owner; dark when nobody owns
  always_ff @(posedge CLK_100 or negedge RST_N) begin
    if (!RST_N) begin
      HEX_OUT   <= '0;
      BLANK_OUT <= 8'hFF;
      DP_OUT    <= '0;
    end else begin
      case (state)
        OWN_A: begin
          HEX_OUT   <= HEX_A;
          BLANK_OUT <= BLANK_A;
          DP_OUT    <= DP_A;
        end
        OWN_B: begin
          HEX_OUT   <= HEX_B;
          BLANK_OUT <= BLANK_B;
          DP_OUT    <= DP_B;
        end
        default: begin
          HEX_OUT   <= '0;
          BLANK_OUT <= 8'hFF;
          DP_OUT    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: scenario tasks compared against a frame-level
// behavioural model (enabled-cycle counting, owner/last/gap bookkeeping).
module tb_seg_display_arbiter;

  localparam int CE_DIV = 4;
  localparam int HOLD   = 2;
  localparam int GAPF   = 1;
  localparam int FRAME  = 8 * CE_DIV;

  logic        clk, rst_n, en, req_a, req_b;
  logic [31:0] hex_a, hex_b;
  logic [7:0]  blank_a, blank_b, dp_a, dp_b;
  logic        gnt_a, gnt_b, ce_out, frame_end;
  logic [31:0] hex_out;
  logic [7:0]  blank_out, dp_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: owner 0 = none, 1 = A, 2 = B
  int          m_en_cnt, m_owner, m_last, m_held, m_gap_left;
  logic        e_ce, e_fe;
  logic [31:0] e_hex;
  logic [7:0]  e_blank, e_dp;

  seg_display_arbiter #(.CE_DIV(CE_DIV), .HOLD_FRAMES(HOLD), .GAP_FRAMES(GAPF)) dut (
    .CLK_100(clk), .RST_N(rst_n), .EN(en), .REQ_A(req_a), .REQ_B(req_b),
    .HEX_A(hex_a), .HEX_B(hex_b), .BLANK_A(blank_a), .BLANK_B(blank_b),
    .DP_A(dp_a), .DP_B(dp_b), .GNT_A(gnt_a), .GNT_B(gnt_b),
    .CE_OUT(ce_out), .FRAME_END(frame_end), .HEX_OUT(hex_out),
    .BLANK_OUT(blank_out), .DP_OUT(dp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [51:0] dut_vec();
    return {gnt_a, gnt_b, ce_out, frame_end, hex_out, blank_out, dp_out};
  endfunction

  function automatic logic [51:0] model_vec();
    return {m_owner == 1, m_owner == 2, e_ce, e_fe, e_hex, e_blank, e_dp};
  endfunction

  task automatic model_reset();
    m_en_cnt = 0; m_owner = 0; m_last = 2; m_held = 0; m_gap_left = 0;
    e_ce = 1'b0; e_fe = 1'b0; e_hex = '0; e_blank = 8'hFF; e_dp = '0;
  endtask

  task automatic m_pick();
    if (req_a && req_b) m_owner = (m_last == 1) ? 2 : 1;
    else if (req_a)     m_owner = 1;
    else if (req_b)     m_owner = 2;
    else                m_owner = 0;
    m_held = 0;
  endtask

  // One clock edge of the reference behaviour
  task automatic m_edge();
    logic mine, other;
    case (m_owner)
      1: begin e_hex = hex_a; e_blank = blank_a; e_dp = dp_a; end
      2: begin e_hex = hex_b; e_blank = blank_b; e_dp = dp_b; end
      default: begin e_hex = '0; e_blank = 8'hFF; e_dp = '0; end
    endcase
    e_ce = 1'b0;
    e_fe = 1'b0;
    if (en) begin
      m_en_cnt++;
      e_ce = (m_en_cnt % CE_DIV == 0);
      e_fe = (m_en_cnt % FRAME == 0);
    end
    if (e_fe) begin
      if (m_gap_left > 0) begin
        m_gap_left--;
        if (m_gap_left == 0) m_pick();
      end else if (m_owner == 0) begin
        m_pick();
      end else begin
        mine  = (m_owner == 1) ? req_a : req_b;
        other = (m_owner == 1) ? req_b : req_a;
        m_held++;
        if (!mine || (other && m_held >= HOLD)) begin
          m_last  = m_owner;
          m_owner = 0;
          if (other) begin
            if (GAPF == 0) m_pick();
            else           m_gap_left = GAPF;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_edge();
    #1;
    cyc++;
  endtask

  task automatic apply_reset(input int edges);
    rst_n = 1'b0;
    model_reset();
    repeat (edges) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    en = 1'b1; req_a = 1'b1; req_b = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({gnt_a, gnt_b, ce_out, frame_end} !== 4'b0000 || hex_out !== 32'h0 ||
        blank_out !== 8'hFF || dp_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values dut=%h exp=%h", dut_vec(), {4'b0, 32'h0, 8'hFF, 8'h00});
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (ce_out !== 1'b0 || gnt_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold ce=%b gnt_a=%b exp 0/0", ce_out, gnt_a);
    end
    rst_n = 1'b1;
    cyc = 0;
    req_a = 1'b0; req_b = 1'b0;
    repeat (4) begin
      tick();
      n_checks++;
      if (ce_out !== (cyc == CE_DIV)) begin
        n_fail++;
        $display("FAIL first_ce cyc=%0d ce=%b exp=%b", cyc, ce_out, cyc == CE_DIV);
      end
    end
  endtask

  task automatic test_free_run();
    int n_ce, n_fe;
    en = 1'b1; req_a = 1'b0; req_b = 1'b0;
    apply_reset(2);
    n_ce = 0; n_fe = 0;
    repeat (64) begin
      tick();
      n_ce += int'(ce_out);
      n_fe += int'(frame_end);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL free_run cyc=%0d dut=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (n_ce != 16 || n_fe != 2) begin
      n_fail++;
      $display("FAIL free_run_counts ce=%0d fe=%0d exp 16/2", n_ce, n_fe);
    end
  endtask

  task automatic test_alternation();
    int a_rise0, a_rise1, a_fall0, b_rise0;
    logic pa, pb;
    en = 1'b1; req_a = 1'b1; req_b = 1'b1;
    hex_a = 32'hAAAA_0001; hex_b = 32'hBBBB_0002;
    apply_reset(2);
    a_rise0 = -1; a_rise1 = -1; a_fall0 = -1; b_rise0 = -1;
    pa = 1'b0; pb = 1'b0;
    repeat (240) begin
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL alternation cyc=%0d dut=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (gnt_a && !pa) begin
        if (a_rise0 < 0) a_rise0 = cyc;
        else if (a_rise1 < 0) a_rise1 = cyc;
      end
      if (!gnt_a && pa && a_fall0 < 0) a_fall0 = cyc;
      if (gnt_b && !pb && b_rise0 < 0) b_rise0 = cyc;
      pa = gnt_a; pb = gnt_b;
    end
    n_checks++;
    if (a_rise0 != 32 || a_fall0 != 96 || b_rise0 != 128 || a_rise1 != 224) begin
      n_fail++;
      $display("FAIL alternation_timing a_up=%0d a_dn=%0d b_up=%0d a_up2=%0d exp 32/96/128/224",
               a_rise0, a_fall0, b_rise0, a_rise1);
    end
  endtask

  task automatic test_single_a();
    int waited;
    en = 1'b1; req_a = 1'b1; req_b = 1'b0;
    hex_a = 32'h1234_5678; blank_a = 8'h00; dp_a = 8'h05;
    apply_reset(2);
    waited = 0;
    while (!gnt_a && waited < 3 * FRAME) begin tick(); waited++; end
    n_checks++;
    if (!gnt_a) begin
      n_fail++;
      $display("FAIL single_a_grant timeout gnt_a=%b exp 1", gnt_a);
    end
    tick();
    n_checks++;
    if (hex_out !== 32'h1234_5678 || dp_out !== 8'h05) begin
      n_fail++;
      $display("FAIL single_a_data hex=%h dp=%h exp 12345678/05", hex_out, dp_out);
    end
    repeat (5) tick();
    req_a = 1'b0;
    waited = 0;
    while (!frame_end && waited < 2 * FRAME) begin
      tick(); waited++;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL single_a_run cyc=%0d dut=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (!frame_end || gnt_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_a_release fe=%b gnt_a=%b exp 1/0", frame_end, gnt_a);
    end
    tick();
    n_checks++;
    if (blank_out !== 8'hFF || hex_out !== 32'h0) begin
      n_fail++;
      $display("FAIL single_a_blank blank=%h hex=%h exp FF/0", blank_out, hex_out);
    end
  endtask

  task automatic test_enable_freeze();
    int ce_at, fe_at;
    en = 1'b1; req_a = 1'b0; req_b = 1'b0;
    apply_reset(2);
    repeat (13) tick();
    en = 1'b0;
    repeat (50) begin
      tick();
      n_checks++;
      if (ce_out !== 1'b0 || frame_end !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_strobe cyc=%0d ce=%b fe=%b exp 0/0", cyc, ce_out, frame_end);
      end
    end
    en = 1'b1;
    ce_at = -1; fe_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ce_out && ce_at < 0) ce_at = i;
      if (frame_end && fe_at < 0) fe_at = i;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL freeze_resume cyc=%0d dut=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (ce_at != 3 || fe_at != 19) begin
      n_fail++;
      $display("FAIL freeze_continue ce_at=%0d fe_at=%0d exp 3/19", ce_at, fe_at);
    end
  endtask

  task automatic test_reset_in_gap();
    en = 1'b1; req_a = 1'b1; req_b = 1'b1;
    apply_reset(2);
    repeat (100) tick();
    n_checks++;
    if (m_gap_left == 0 || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_reached gnt_a=%b gnt_b=%b exp 0/0 in gap", gnt_a, gnt_b);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt_a, gnt_b, ce_out, frame_end} !== 4'b0000 || hex_out !== 32'h0 ||
        blank_out !== 8'hFF || dp_out !== 8'h00) begin
      n_fail++;
      $display("FAIL gap_reset dut=%h exp=%h", dut_vec(), {4'b0, 32'h0, 8'hFF, 8'h00});
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    repeat (FRAME) begin
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL gap_restart cyc=%0d dut=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_restart_owner gnt_a=%b gnt_b=%b exp 1/0", gnt_a, gnt_b);
    end
  endtask

  task automatic test_req_pulse();
    en = 1'b1; req_a = 1'b1; req_b = 1'b0;
    apply_reset(2);
    repeat (FRAME + 10) tick();
    req_b = 1'b1;
    repeat (3) tick();
    req_b = 1'b0;
    repeat (3 * FRAME) begin
      tick();
      n_checks++;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL req_pulse cyc=%0d dut=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    en = 1'b1; req_a = 1'b0; req_b = 1'b0;
    apply_reset(2);
    repeat (3000) begin
      if ($urandom_range(0, 119) == 0) req_a = ~req_a;
      if ($urandom_range(0, 119) == 0) req_b = ~req_b;
      en      = ($urandom_range(0, 9) != 0);
      hex_a   = $urandom; hex_b = $urandom;
      blank_a = 8'($urandom); blank_b = 8'($urandom);
      dp_a    = 8'($urandom); dp_b = 8'($urandom);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d dut=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; req_a = 1'b0; req_b = 1'b0;
    hex_a = 32'h0; hex_b = 32'h0;
    blank_a = 8'h00; blank_b = 8'h00; dp_a = 8'h00; dp_b = 8'h00;
    model_reset();
    test_reset();
    test_free_run();
    test_alternation();
    test_single_a();
    test_enable_freeze();
    test_reset_in_gap();
    test_req_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
